// File: rtl/pdn_seq_pkg.sv
// pdn_seq_pkg
// Shared definitions for the power-delivery rail sequencer.
// Contents:
//   DEFAULT_NUM_RAILS / DEFAULT_SETTLE_CYCLES / DEFAULT_TIMEOUT_CYCLES
//     - default parameter values used by pdn_rail_sequencer
//   FAULT_RAIL_W - width of the fault_rail report port
//   seq_state_e  - sequencer FSM states
package pdn_seq_pkg;

  localparam int DEFAULT_NUM_RAILS      = 6;
  localparam int DEFAULT_SETTLE_CYCLES  = 16;
  localparam int DEFAULT_TIMEOUT_CYCLES = 255;
  localparam int FAULT_RAIL_W           = 3;

  typedef enum logic [2:0] {
    ST_OFF,
    ST_RAMP_UP,
    ST_SETTLE,
    ST_ON,
    ST_RAMP_DOWN,
    ST_FAULT
  } seq_state_e;

endpackage

// File: rtl/pdn_seq_timer.sv
// pdn_seq_timer
// Load / decrement / expire down-counter used by the rail sequencer for both
// the settle delay and the power-good timeouts.
// Ports:
//   clk      - clock
//   rst_n    - asynchronous active-low reset, clears the count
//   load     - load load_val this cycle (takes priority over counting)
//   load_val - value to load
//   expired  - high while the count sits at zero
module pdn_seq_timer
  import pdn_seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic             expired
);

  logic [WIDTH-1:0] count;

  // Counter register: a load always wins, otherwise count down and stick at
  // zero so that "expired" stays asserted until the next load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - WIDTH'(1);
    end
  end

  assign expired = (count == '0);

endmodule

// File: rtl/pdn_rail_sequencer.sv
// pdn_rail_sequencer
// Powers a set of supply rails up in order 0..NUM_RAILS-1 (waiting for each
// power-good plus a settle delay) and down in reverse order, with timeout and
// power-good-drop fault detection.
// Ports:
//   clk        - clock (single domain)
//   rst_n      - asynchronous active-low reset
//   pwr_req    - level request, 1 = power up, 0 = power down
//   rail_pg    - per-rail power-good, synchronous to clk
//   rail_en    - per-rail enable (registered)
//   pwr_ok     - all rails up and settled (registered)
//   busy       - sequencing in progress (registered)
//   fault      - sticky fault flag, cleared by dropping pwr_req (registered)
//   fault_rail - rail index that caused the last fault (registered)
module pdn_rail_sequencer
  import pdn_seq_pkg::*;
#(
  parameter int NUM_RAILS      = DEFAULT_NUM_RAILS,
  parameter int SETTLE_CYCLES  = DEFAULT_SETTLE_CYCLES,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    pwr_req,
  input  logic [NUM_RAILS-1:0]    rail_pg,
  output logic [NUM_RAILS-1:0]    rail_en,
  output logic                    pwr_ok,
  output logic                    busy,
  output logic                    fault,
  output logic [FAULT_RAIL_W-1:0] fault_rail
);

  localparam int IDX_W    = (NUM_RAILS > 1) ? $clog2(NUM_RAILS) : 1;
  localparam int MAX_WAIT = (SETTLE_CYCLES > TIMEOUT_CYCLES) ? SETTLE_CYCLES : TIMEOUT_CYCLES;
  localparam int TMR_W    = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;

  localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(NUM_RAILS - 1);
  localparam logic [TMR_W-1:0] SETTLE_LOAD = TMR_W'(SETTLE_CYCLES);
  localparam logic [TMR_W-1:0] TIMEOUT_LOAD =
    (TIMEOUT_CYCLES > 0) ? TMR_W'(TIMEOUT_CYCLES - 1) : '0;

  seq_state_e              state;
  seq_state_e              state_nx;
  logic [IDX_W-1:0]        idx;
  logic [IDX_W-1:0]        idx_nx;
  logic [FAULT_RAIL_W-1:0] fault_rail_nx;
  logic [FAULT_RAIL_W-1:0] idx_rail;
  logic [NUM_RAILS-1:0]    rail_en_nx;
  logic                    drop_found;
  logic [FAULT_RAIL_W-1:0] drop_rail;
  logic                    tmr_load;
  logic [TMR_W-1:0]        tmr_val;
  logic                    tmr_expired;

  assign idx_rail = FAULT_RAIL_W'(idx);

  // The timeout timer is loaded with TIMEOUT_CYCLES-1 and expiry is judged on
  // the sampled count, so the fault is taken on the TIMEOUT_CYCLES-th cycle
  // spent waiting. The settle load of SETTLE_CYCLES makes the next enable
  // rise SETTLE_CYCLES+1 cycles after power-good was first seen.
  pdn_seq_timer #(
    .WIDTH(TMR_W)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .expired  (tmr_expired)
  );

  // Find the lowest rail at or below idx whose power-good is low. Scanning
  // from the top down lets the lowest hit overwrite any higher one.
  always_comb begin
    drop_found = 1'b0;
    drop_rail  = '0;
    for (int k = NUM_RAILS - 1; k >= 0; k--) begin
      if ((k <= int'(idx)) && !rail_pg[k]) begin
        drop_found = 1'b1;
        drop_rail  = FAULT_RAIL_W'(k);
      end
    end
  end

  // Next-state logic. Within each state the checks are ordered fault first,
  // then request removal, then normal power-good progress, so simultaneous
  // events resolve in that priority.
  always_comb begin
    state_nx      = state;
    idx_nx        = idx;
    fault_rail_nx = fault_rail;
    case (state)
      ST_OFF: begin
        if (pwr_req) begin
          state_nx = ST_RAMP_UP;
          idx_nx   = '0;
        end
      end
      ST_RAMP_UP: begin
        if (tmr_expired && !rail_pg[idx]) begin
          state_nx      = ST_FAULT;
          fault_rail_nx = idx_rail;
        end else if (!pwr_req) begin
          state_nx = ST_RAMP_DOWN;
        end else if (rail_pg[idx]) begin
          state_nx = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (drop_found) begin
          state_nx      = ST_FAULT;
          fault_rail_nx = drop_rail;
        end else if (!pwr_req) begin
          state_nx = ST_RAMP_DOWN;
        end else if (tmr_expired) begin
          if (idx == LAST_IDX) begin
            state_nx = ST_ON;
          end else begin
            state_nx = ST_RAMP_UP;
            idx_nx   = idx + IDX_W'(1);
          end
        end
      end
      ST_ON: begin
        if (drop_found) begin
          state_nx      = ST_FAULT;
          fault_rail_nx = drop_rail;
        end else if (!pwr_req) begin
          state_nx = ST_RAMP_DOWN;
        end
      end
      ST_RAMP_DOWN: begin
        if (tmr_expired && rail_pg[idx]) begin
          state_nx      = ST_FAULT;
          fault_rail_nx = idx_rail;
        end else if (!rail_pg[idx]) begin
          if (idx == '0) begin
            state_nx = ST_OFF;
          end else begin
            idx_nx = idx - IDX_W'(1);
          end
        end
      end
      ST_FAULT: begin
        if (!pwr_req) begin
          state_nx = ST_OFF;
        end
      end
      default: begin
        state_nx = ST_OFF;
      end
    endcase
  end

  // Enables follow directly from where the FSM is heading: rails up to idx
  // while ramping up or settling, all rails when on, and only the rails below
  // idx while ramping down (rail idx is the one being switched off).
  always_comb begin
    rail_en_nx = '0;
    for (int k = 0; k < NUM_RAILS; k++) begin
      case (state_nx)
        ST_RAMP_UP, ST_SETTLE: rail_en_nx[k] = (k <= int'(idx_nx));
        ST_ON:                 rail_en_nx[k] = 1'b1;
        ST_RAMP_DOWN:          rail_en_nx[k] = (k < int'(idx_nx));
        default:               rail_en_nx[k] = 1'b0;
      endcase
    end
  end

  // Timer reload on any change of state or rail index, with the value that
  // suits the state being entered.
  always_comb begin
    tmr_load = (state_nx != state) || (idx_nx != idx);
    case (state_nx)
      ST_SETTLE:                tmr_val = SETTLE_LOAD;
      ST_RAMP_UP, ST_RAMP_DOWN: tmr_val = TIMEOUT_LOAD;
      default:                  tmr_val = '0;
    endcase
  end

  // State and output registers. Outputs are decoded from next-state values
  // so that they are flop outputs yet line up with the state they describe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_OFF;
      idx        <= '0;
      rail_en    <= '0;
      pwr_ok     <= 1'b0;
      busy       <= 1'b0;
      fault      <= 1'b0;
      fault_rail <= '0;
    end else begin
      state      <= state_nx;
      idx        <= idx_nx;
      rail_en    <= rail_en_nx;
      pwr_ok     <= (state_nx == ST_ON);
      busy       <= (state_nx == ST_RAMP_UP) || (state_nx == ST_SETTLE) ||
                    (state_nx == ST_RAMP_DOWN);
      fault      <= (state_nx == ST_FAULT);
      fault_rail <= fault_rail_nx;
    end
  end

endmodule

// File: tb/tb_pdn_rail_sequencer.sv
// tb_pdn_rail_sequencer
// Self-checking bench for pdn_rail_sequencer. A rail "plant" answers each
// enable with a power-good after a random delay (with optional stuck-low
// rails), and a cycle-level reference model built from counts and timestamps
// predicts every output after every clock edge.
module tb_pdn_rail_sequencer;

  localparam int NR = 6;
  localparam int S  = 4;
  localparam int T  = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          pwr_req;
  logic [NR-1:0] rail_pg;
  logic [NR-1:0] rail_en;
  logic          pwr_ok;
  logic          busy;
  logic          fault;
  logic [2:0]    fault_rail;

  int checks = 0;
  int errors = 0;

  int m_now;
  int m_en_count;
  int m_dir;
  int m_wait;
  int m_seen_at;
  int m_down_idx;
  int m_fault_rail;
  bit m_ok;
  bit m_fault;

  logic [NR-1:0] stuck;
  int pg_cnt [NR];
  int dly_lo;
  int dly_hi;

  int cyc;
  int pg5_at;
  int ok_at;
  int fault_at;
  int en_rise_at [NR];
  int r;

  pdn_rail_sequencer #(
    .NUM_RAILS      (NR),
    .SETTLE_CYCLES  (S),
    .TIMEOUT_CYCLES (T)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pwr_req    (pwr_req),
    .rail_pg    (rail_pg),
    .rail_en    (rail_en),
    .pwr_ok     (pwr_ok),
    .busy       (busy),
    .fault      (fault),
    .fault_rail (fault_rail)
  );

  // Free-running 10 ns clock.
  always #5 clk = ~clk;

  function automatic void modelReset();
    m_now        = 0;
    m_en_count   = 0;
    m_dir        = 0;
    m_wait       = 0;
    m_seen_at    = -1;
    m_down_idx   = 0;
    m_fault_rail = 0;
    m_ok         = 1'b0;
    m_fault      = 1'b0;
  endfunction

  function automatic logic [NR-1:0] modelEn();
    logic [NR-1:0] v;
    v = '0;
    for (int k = 0; k < m_en_count; k++) v[k] = 1'b1;
    return v;
  endfunction

  function automatic int lowestLow(input logic [NR-1:0] pg, input int upto);
    for (int k = 0; k <= upto; k++) begin
      if (!pg[k]) return k;
    end
    return -1;
  endfunction

  function automatic void enterFault(input int k);
    m_fault      = 1'b1;
    m_fault_rail = k;
    m_en_count   = 0;
    m_ok         = 1'b0;
    m_dir        = 0;
  endfunction

  function automatic void startDown(input int d);
    m_dir      = -1;
    m_ok       = 1'b0;
    m_down_idx = d;
    m_en_count = d;
    m_wait     = 0;
    m_seen_at  = -1;
  endfunction

  // One clock edge of the reference: m_en_count rails are on, rail
  // m_en_count-1 is the one being brought up (m_dir=+1), m_down_idx the one
  // being brought down (m_dir=-1). Settle is a timestamp, timeouts a count.
  function automatic void modelStep(input bit req, input logic [NR-1:0] pg);
    int cur;
    int low;
    m_now++;
    if (m_fault) begin
      if (!req) m_fault = 1'b0;
    end else if (m_ok) begin
      low = lowestLow(pg, NR - 1);
      if (low >= 0) enterFault(low);
      else if (!req) startDown(NR - 1);
    end else if (m_dir == 0) begin
      if (req) begin
        m_dir      = 1;
        m_en_count = 1;
        m_wait     = 0;
        m_seen_at  = -1;
      end
    end else if (m_dir == 1) begin
      cur = m_en_count - 1;
      if (m_seen_at >= 0) begin
        low = lowestLow(pg, cur);
        if (low >= 0) enterFault(low);
        else if (!req) startDown(cur);
        else if (m_now == m_seen_at + S + 1) begin
          if (cur == NR - 1) begin
            m_ok  = 1'b1;
            m_dir = 0;
          end else begin
            m_en_count++;
            m_seen_at = -1;
            m_wait    = 0;
          end
        end
      end else begin
        if (!pg[cur] && (m_wait + 1 == T)) enterFault(cur);
        else if (!req) startDown(cur);
        else if (pg[cur]) m_seen_at = m_now;
        else m_wait++;
      end
    end else begin
      if (!pg[m_down_idx]) begin
        if (m_down_idx == 0) begin
          m_dir = 0;
        end else begin
          m_down_idx--;
          m_en_count = m_down_idx;
          m_wait     = 0;
        end
      end else if (m_wait + 1 == T) begin
        enterFault(m_down_idx);
      end else begin
        m_wait++;
      end
    end
  endfunction

  task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput();
    checkEq("rail_en", 32'(rail_en), 32'(modelEn()));
    checkEq("pwr_ok", 32'(pwr_ok), 32'(m_ok));
    checkEq("busy", 32'(busy), 32'(m_dir != 0));
    checkEq("fault", 32'(fault), 32'(m_fault));
    checkEq("fault_rail", 32'(fault_rail), 32'(m_fault_rail));
  endtask

  // Rails follow the expected enables after a random delay; stuck rails stay low.
  task automatic plantUpdate();
    logic [NR-1:0] en;
    en = modelEn();
    for (int k = 0; k < NR; k++) begin
      if (stuck[k]) begin
        rail_pg[k] = 1'b0;
      end else if (rail_pg[k] != en[k]) begin
        if (pg_cnt[k] == 0) rail_pg[k] = en[k];
        else pg_cnt[k]--;
      end else begin
        pg_cnt[k] = $urandom_range(dly_hi, dly_lo);
      end
    end
  endtask

  task automatic clearMarks();
    pg5_at   = -1;
    ok_at    = -1;
    fault_at = -1;
    for (int k = 0; k < NR; k++) en_rise_at[k] = -1;
  endtask

  task automatic applyStimulus();
    if (rail_pg[NR-1] && (pg5_at < 0)) pg5_at = cyc + 1;
    modelStep(pwr_req, rail_pg);
    @(posedge clk);
    #1;
    cyc++;
    checkOutput();
    if (pwr_ok && (ok_at < 0)) ok_at = cyc;
    if (fault && (fault_at < 0)) fault_at = cyc;
    for (int k = 0; k < NR; k++) begin
      if (rail_en[k] && (en_rise_at[k] < 0)) en_rise_at[k] = cyc;
    end
    plantUpdate();
  endtask

  initial begin
    rst_n   = 1'b1;
    pwr_req = 1'b0;
    rail_pg = '0;
    stuck   = '0;
    dly_lo  = 1;
    dly_hi  = 1;
    cyc     = 0;
    for (int k = 0; k < NR; k++) pg_cnt[k] = 0;
    modelReset();
    clearMarks();

    $display("[TB] reset values");
    #2 rst_n = 1'b0;
    #10;
    checkEq("rst_rail_en", 32'(rail_en), 32'h0);
    checkEq("rst_pwr_ok", 32'(pwr_ok), 32'h0);
    checkEq("rst_busy", 32'(busy), 32'h0);
    checkEq("rst_fault", 32'(fault), 32'h0);
    checkEq("rst_fault_rail", 32'(fault_rail), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus();
    applyStimulus();

    $display("[TB] nominal power-up");
    clearMarks();
    pwr_req = 1'b1;
    for (int c = 0; c < 300 && !m_ok; c++) applyStimulus();
    applyStimulus();
    checkEq("pwrup_ok", 32'(pwr_ok), 32'h1);
    checkEq("pwrup_rails", 32'(rail_en), 32'h3F);
    checkEq("pwrup_latency", 32'(ok_at - pg5_at), 32'(S + 1));
    for (int k = 1; k < NR; k++) begin
      checkEq("rise_order", 32'(en_rise_at[k] > en_rise_at[k-1]), 32'h1);
    end

    $display("[TB] power-down");
    dly_lo  = 0;
    dly_hi  = 3;
    pwr_req = 1'b0;
    for (int c = 0; c < 300 && (m_dir != 0 || m_ok); c++) applyStimulus();
    applyStimulus();
    checkEq("pwrdn_busy", 32'(busy), 32'h0);
    checkEq("pwrdn_rails", 32'(rail_en), 32'h0);

    $display("[TB] timeout on rail 2");
    clearMarks();
    stuck   = 6'b000100;
    pwr_req = 1'b1;
    for (int c = 0; c < 300 && !m_fault; c++) applyStimulus();
    applyStimulus();
    checkEq("tmo_fault", 32'(fault), 32'h1);
    checkEq("tmo_rail", 32'(fault_rail), 32'h2);
    checkEq("tmo_rails_off", 32'(rail_en), 32'h0);
    checkEq("tmo_cycles", 32'(fault_at - en_rise_at[2]), 32'(T));
    pwr_req = 1'b0;
    applyStimulus();
    checkEq("tmo_clear", 32'(fault), 32'h0);
    checkEq("tmo_rail_kept", 32'(fault_rail), 32'h2);
    stuck = '0;
    for (int c = 0; c < 6; c++) applyStimulus();

    $display("[TB] drop of rail 1 while on");
    pwr_req = 1'b1;
    for (int c = 0; c < 300 && !m_ok; c++) applyStimulus();
    applyStimulus();
    stuck      = 6'b000010;
    rail_pg[1] = 1'b0;
    applyStimulus();
    checkEq("drop_fault", 32'(fault), 32'h1);
    checkEq("drop_rail", 32'(fault_rail), 32'h1);
    checkEq("drop_pwr_ok", 32'(pwr_ok), 32'h0);
    checkEq("drop_rails_off", 32'(rail_en), 32'h0);
    pwr_req = 1'b0;
    stuck   = '0;
    for (int c = 0; c < 6; c++) applyStimulus();

    $display("[TB] request drop with rail 3 power-good");
    clearMarks();
    dly_lo  = 0;
    dly_hi  = 2;
    stuck   = 6'b001000;
    pwr_req = 1'b1;
    for (int c = 0; c < 300 && m_en_count != 4; c++) applyStimulus();
    for (int c = 0; c < 3; c++) applyStimulus();
    stuck      = '0;
    rail_pg[3] = 1'b1;
    pwr_req    = 1'b0;
    applyStimulus();
    checkEq("reqdrop_rails", 32'(rail_en), 32'h07);
    checkEq("reqdrop_busy", 32'(busy), 32'h1);
    for (int c = 0; c < 300 && m_dir != 0; c++) applyStimulus();
    checkEq("reqdrop_en4_never", 32'(en_rise_at[4]), 32'hFFFF_FFFF);

    $display("[TB] reset during settle of rail 4");
    dly_lo  = 1;
    dly_hi  = 1;
    pwr_req = 1'b1;
    for (int c = 0; c < 300 && !(m_en_count == 5 && m_seen_at >= 0); c++) applyStimulus();
    applyStimulus();
    #2 rst_n = 1'b0;
    #1;
    checkEq("arst_rail_en", 32'(rail_en), 32'h0);
    checkEq("arst_busy", 32'(busy), 32'h0);
    checkEq("arst_pwr_ok", 32'(pwr_ok), 32'h0);
    checkEq("arst_fault", 32'(fault), 32'h0);
    modelReset();
    rail_pg = '0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 300 && !m_ok; c++) applyStimulus();
    applyStimulus();
    checkEq("arst_repower_ok", 32'(pwr_ok), 32'h1);
    checkEq("arst_repower_rails", 32'(rail_en), 32'h3F);

    $display("[TB] random traffic");
    dly_lo = 0;
    dly_hi = 3;
    for (int c = 0; c < 1500; c++) begin
      r = $urandom_range(99, 0);
      if (r < 3) begin
        pwr_req = ~pwr_req;
      end else if (r == 50) begin
        stuck = '0;
        stuck[$urandom_range(NR - 1, 0)] = 1'b1;
      end else if (r >= 96) begin
        stuck = '0;
      end
      applyStimulus();
    end
    stuck   = '0;
    pwr_req = 1'b0;
    for (int c = 0; c < 300 && (m_dir != 0 || m_ok || m_fault); c++) applyStimulus();
    checkEq("final_idle_busy", 32'(busy), 32'h0);
    checkEq("final_idle_rails", 32'(rail_en), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pdn_rail_sequencer.md
PDN_RAIL_SEQUENCER -- requirements
Module: pdn_rail_sequencer

Interface
REQ-001 SHALL have parameter NUM_RAILS, default 6: number of supply rails sequenced; rail index 0 is VDD1 through index 5 for VDD6.
REQ-002 SHALL have parameter SETTLE_CYCLES, default 16: settle delay after a rail reports power-good.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 255: maximum wait for a power-good edge.
REQ-004 SHALL have port clk  input  1  the single clock; all logic is in this one clock domain.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port pwr_req  input  1  level request: 1 = power up all rails, 0 = power down.
REQ-007 SHALL have port rail_pg  input  NUM_RAILS  per-rail power-good, already synchronous to clk.
REQ-008 SHALL have port rail_en  output  NUM_RAILS  per-rail supply enable, registered.
REQ-009 SHALL have port pwr_ok  output  1  all rails up and settled.
REQ-010 SHALL have port busy  output  1  high in RAMP_UP, SETTLE and RAMP_DOWN.
REQ-011 SHALL have port fault  output  1  sticky fault flag.
REQ-012 SHALL have port fault_rail  output  3  index of the rail that caused the fault.

Function
REQ-013 SHALL implement the states OFF, RAMP_UP, SETTLE, ON, RAMP_DOWN and FAULT, plus a rail index idx of width clog2(NUM_RAILS).
REQ-014 In OFF with pwr_req=1, the block SHALL go to RAMP_UP with idx=0 and assert rail_en[0] on the next cycle.
REQ-015 In RAMP_UP, when rail_pg[idx]=1 is sampled, the block SHALL go to SETTLE and load the timer with SETTLE_CYCLES.
REQ-016 SETTLE expiry with idx<NUM_RAILS-1 SHALL increment idx, assert rail_en[idx+1] and return to RAMP_UP; with idx=NUM_RAILS-1 the block SHALL go to ON and set pwr_ok=1.
REQ-017 rail_en[idx+1] SHALL rise exactly SETTLE_CYCLES+1 cycles after rail_pg[idx] is first sampled high.
REQ-018 In RAMP_UP, TIMEOUT_CYCLES cycles without rail_pg[idx] SHALL cause FAULT with fault_rail=idx.
REQ-019 In SETTLE or ON, a drop of any rail_pg[k] with k<=idx SHALL cause FAULT with fault_rail set to the lowest such k.
REQ-020 pwr_req=0 in RAMP_UP, SETTLE or ON SHALL cause RAMP_DOWN at the current idx and clear pwr_ok and rail_en[idx] on the next cycle.
REQ-021 In RAMP_DOWN, when rail_pg[idx]=0 is sampled, the block SHALL decrement idx and clear rail_en[idx-1]; with idx=0 it SHALL go to OFF.
REQ-022 Rails SHALL power down in reverse order (NUM_RAILS-1 down to 0), with no settle delay between rails.
REQ-023 In RAMP_DOWN, TIMEOUT_CYCLES cycles without rail_pg[idx] falling SHALL cause FAULT with fault_rail=idx.
REQ-024 Entry to FAULT SHALL clear all rail_en bits, pwr_ok and busy on the next cycle and set fault=1.
REQ-025 FAULT SHALL be held while pwr_req=1; pwr_req=0 in FAULT SHALL clear fault and return to OFF, leaving fault_rail unchanged.
REQ-026 Priority for simultaneous events SHALL be fault > pwr_req deassertion > pg progress; for example, pg rising on the same cycle pwr_req falls SHALL lead to RAMP_DOWN.
REQ-027 pwr_req=1 in RAMP_DOWN SHALL be ignored until the block reaches OFF.
REQ-028 The timer SHALL saturate at zero, SHALL reload on every state or idx change, and SHALL be wide enough for the larger of SETTLE_CYCLES and TIMEOUT_CYCLES.
REQ-029 Every output SHALL be driven directly from a flop, with no combinational path from any input to any output.

Reset
REQ-030 rst_n=0 SHALL asynchronously force state=OFF, idx=0, timer=0, rail_en=0, pwr_ok=0, busy=0, fault=0 and fault_rail=0.
REQ-031 Reset asserted mid-sequence SHALL drop all rail_en bits immediately, and the block SHALL restart from OFF once rst_n is released.

Structure
REQ-032 The state enum, default parameter values and the fault_rail width SHALL live in the shared package pdn_seq_pkg.
REQ-033 The load/decrement/expire counter SHALL be the single sub-module pdn_seq_timer; the FSM SHALL be in pdn_rail_sequencer.

Verification
REQ-034 Nominal power-up (SETTLE_CYCLES=4; pg rises 2 cycles after each enable) -> rail_en rises in order 0..5, and pwr_ok=1 exactly 5 cycles after rail_pg[5] is first sampled high.
REQ-035 Power-down from ON with pwr_req=0 -> rail_en[5] clears first, each lower rail clears one cycle after the rail above shows pg=0, and the block ends in OFF with busy=0.
REQ-036 rail_pg[2] held at 0 with TIMEOUT_CYCLES=8 -> FAULT after 8 cycles in RAMP_UP with fault_rail=2 and rail_en=0; then pwr_req=0 -> fault=0 and state OFF.
REQ-037 rail_pg[1] dropped while in ON -> fault=1, fault_rail=1, pwr_ok=0 and all rail_en bits cleared the next cycle.
REQ-038 pwr_req falls on the same cycle rail_pg[3] rises -> RAMP_DOWN from idx=3, and rail_en[4] never asserts.
REQ-039 rst_n asserted during SETTLE of rail 4 -> all outputs 0 asynchronously, and after release a full nominal power-up sequence completes.
